// File: rtl/autobaud_pkg.sv
// Shared definitions for the autobaud divisor sequencer: default sizing,
// FSM state encoding and the width rule for the saturating rounding add.
// Imported by autobaud_div_seq and its divider.
package autobaud_pkg;

   // Default sizing
   localparam int AB_W_DEF           = 20;
   localparam int AB_N_DEF           = 6;
   localparam int AB_BITS_DEF        = 8;
   localparam int AB_OVS_DEF         = 16;
   localparam int AB_MIN_BIT_DIV_DEF = 8;

   // Sequencer state encoding
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_DIV1  = 3'd1;
   localparam logic [2:0] ST_WAIT1 = 3'd2;
   localparam logic [2:0] ST_DIV2  = 3'd3;
   localparam logic [2:0] ST_WAIT2 = 3'd4;
   localparam logic [2:0] ST_CHECK = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE  = ST_IDLE,
      S_DIV1  = ST_DIV1,
      S_WAIT1 = ST_WAIT1,
      S_DIV2  = ST_DIV2,
      S_WAIT2 = ST_WAIT2,
      S_CHECK = ST_CHECK
   } ab_state_t;

   // A rounding offset is added one bit wider than the datapath so the
   // carry-out can be seen and the sum saturated instead of wrapping.
   function automatic int sat_sum_width(input int w);
      return w + 1;
   endfunction

endpackage

// File: rtl/autobaud_div_seq_div.sv
// Radix-2 restoring serial divider, one quotient bit per clock.
// Latency: start sampled at edge k, done_tick high in the cycle after edge k+W+1.
// Backpressure: ready is low while a division runs; start is ignored then.
module div
   import autobaud_pkg::*;
#(
   parameter int W = AB_W_DEF,
   parameter int N = AB_N_DEF
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         ready,
   output logic         done_tick,
   output logic [W-1:0] quotient
);

   typedef enum logic [1:0] {D_IDLE, D_RUN, D_FIN} div_state_t;

   div_state_t   dstate;
   logic [W-1:0] rem;
   logic [W-1:0] q;
   logic [W-1:0] dvs;
   logic [N-1:0] cnt;
   logic [W:0]   trial;
   logic [W-1:0] diff;

   // Shift the next dividend bit into the partial remainder. When the trial
   // is at least the divisor the difference is below the divisor, so the
   // low W bits of the subtraction are exact.
   assign trial = {rem, q[W-1]};
   assign diff  = trial[W-1:0] - dvs;
   assign ready = (dstate == D_IDLE);

   // Load operands, run W shift/subtract steps, then publish the quotient
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         dstate    <= D_IDLE;
         rem       <= '0;
         q         <= '0;
         dvs       <= '0;
         cnt       <= '0;
         done_tick <= 1'b0;
         quotient  <= '0;
      end else begin
         done_tick <= 1'b0;
         case (dstate)
            D_IDLE: begin
               if (start) begin
                  rem    <= '0;
                  q      <= dividend;
                  dvs    <= divisor;
                  cnt    <= N'(W);
                  dstate <= D_RUN;
               end
            end
            D_RUN: begin
               if (trial >= {1'b0, dvs}) begin
                  rem <= diff;
                  q   <= {q[W-2:0], 1'b1};
               end else begin
                  rem <= trial[W-1:0];
                  q   <= {q[W-2:0], 1'b0};
               end
               cnt <= cnt - N'(1);
               if (cnt == N'(1)) begin
                  dstate <= D_FIN;
               end
            end
            D_FIN: begin
               quotient  <= q;
               done_tick <= 1'b1;
               dstate    <= D_IDLE;
            end
            default: dstate <= D_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/autobaud_div_seq.sv
// Turns one sync-character span into bit and oversample divisors via two serial divisions.
// Latency: 2W+7 cycles from meas_valid to baud_valid/baud_err (47 at W=20).
// Backpressure: none upstream; meas_valid while busy is dropped. Build option: AUTOBAUD_ROUND_EN.
module autobaud_div_seq
   import autobaud_pkg::*;
#(
   parameter int W           = AB_W_DEF,
   parameter int N           = AB_N_DEF,
   parameter int BITS        = AB_BITS_DEF,
   parameter int OVS         = AB_OVS_DEF,
   parameter int MIN_BIT_DIV = AB_MIN_BIT_DIV_DEF
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         meas_valid,
   input  logic [W-1:0] meas_cycles,
   output logic         busy,
   output logic         baud_valid,
   output logic         baud_err,
   output logic [W-1:0] bit_div,
   output logic [W-1:0] os_div
);

`ifdef AUTOBAUD_ROUND_EN
   localparam int BIT_OFS = BITS / 2;
   localparam int OS_OFS  = OVS / 2;
`else
   localparam int BIT_OFS = 0;
   localparam int OS_OFS  = 0;
`endif

   localparam int SW = sat_sum_width(W);

   ab_state_t    state;
   logic [W-1:0] meas_q;
   logic [W-1:0] q1;
   logic [SW-1:0] sum_bit;
   logic [SW-1:0] sum_os;
   logic [W-1:0] dvd_bit;
   logic [W-1:0] dvd_os;

   logic         div_start;
   logic [W-1:0] div_dividend;
   logic [W-1:0] div_divisor;
   logic         div_ready;
   logic         div_done;
   logic [W-1:0] div_quot;

   // Rounding offsets saturate to all-ones on carry-out rather than wrapping
   assign sum_bit = {1'b0, meas_q} + SW'(BIT_OFS);
   assign sum_os  = {1'b0, q1} + SW'(OS_OFS);
   assign dvd_bit = sum_bit[W] ? '1 : sum_bit[W-1:0];
   assign dvd_os  = sum_os[W]  ? '1 : sum_os[W-1:0];

   // The shared divider is started only from the issue states and only when it can accept
   assign div_start    = ((state == S_DIV1) || (state == S_DIV2)) && div_ready;
   assign div_dividend = (state == S_DIV2) ? dvd_os : dvd_bit;
   assign div_divisor  = (state == S_DIV2) ? W'(OVS) : W'(BITS);

   div #(
      .W(W),
      .N(N)
   ) u_div (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (div_start),
      .dividend  (div_dividend),
      .divisor   (div_divisor),
      .ready     (div_ready),
      .done_tick (div_done),
      .quotient  (div_quot)
   );

   // Sequencer: two divisions back to back, then a single result or error pulse.
   // The second quotient is judged straight off the divider on its done_tick so
   // the pulse is registered into the CHECK cycle; CHECK then retires to IDLE.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         busy       <= 1'b0;
         baud_valid <= 1'b0;
         baud_err   <= 1'b0;
         bit_div    <= '0;
         os_div     <= '0;
         meas_q     <= '0;
         q1         <= '0;
      end else begin
         baud_valid <= 1'b0;
         baud_err   <= 1'b0;
         case (state)
            S_IDLE: begin
               if (meas_valid) begin
                  meas_q <= meas_cycles;
                  busy   <= 1'b1;
                  state  <= S_DIV1;
               end
            end
            S_DIV1: begin
               if (div_ready) begin
                  state <= S_WAIT1;
               end
            end
            S_WAIT1: begin
               if (div_done) begin
                  q1    <= div_quot;
                  state <= S_DIV2;
               end
            end
            S_DIV2: begin
               if (div_ready) begin
                  state <= S_WAIT2;
               end
            end
            S_WAIT2: begin
               if (div_done) begin
                  state <= S_CHECK;
                  if ((q1 < W'(MIN_BIT_DIV)) || (div_quot == '0)) begin
                     baud_err <= 1'b1;
                  end else begin
                     baud_valid <= 1'b1;
                     bit_div    <= q1;
                     os_div     <= div_quot;
                  end
               end
            end
            S_CHECK: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_autobaud_div_seq.sv
// Directed bench for autobaud_div_seq at default sizing (W=20, BITS=8, OVS=16).
// Expected divisors follow the AUTOBAUD_ROUND_EN build option.
// Cycle c below is the value seen between edge c-1 and edge c; edge 0 samples meas_valid.
module tb_autobaud_div_seq;

   logic        clk;
   logic        reset_n;
   logic        meas_valid;
   logic [19:0] meas_cycles;
   logic        busy;
   logic        baud_valid;
   logic        baud_err;
   logic [19:0] bit_div;
   logic [19:0] os_div;

   int checks;
   int errors;

`ifdef AUTOBAUD_ROUND_EN
   localparam logic [19:0] EXP_9600_OS = 20'd326;
   localparam logic [19:0] EXP_SAT_OS  = 20'd8192;
`else
   localparam logic [19:0] EXP_9600_OS = 20'd325;
   localparam logic [19:0] EXP_SAT_OS  = 20'd8191;
`endif

   autobaud_div_seq dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .meas_valid  (meas_valid),
      .meas_cycles (meas_cycles),
      .busy        (busy),
      .baud_valid  (baud_valid),
      .baud_err    (baud_err),
      .bit_div     (bit_div),
      .os_div      (os_div)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stimulus/observation: sends one measurement, then observes ncyc cycles,
   // optionally injecting extra meas_valid pulses or a one-cycle reset.
   task automatic run_meas(input logic [19:0] val, input int inj_a, input int inj_b,
                           input int rst_at, input int ncyc,
                           output int first_v, output int last_v, output int first_e,
                           output int n_v, output int n_e, output int busy_cnt, output int both);
      first_v = -1; last_v = -1; first_e = -1;
      n_v = 0; n_e = 0; busy_cnt = 0; both = 0;
      @(negedge clk);
      meas_valid  = 1'b1;
      meas_cycles = val;
      @(negedge clk);
      meas_valid = 1'b0;
      for (int c = 1; c <= ncyc; c++) begin
         if (baud_valid) begin
            n_v++;
            last_v = c;
            if (first_v < 0) first_v = c;
         end
         if (baud_err) begin
            n_e++;
            if (first_e < 0) first_e = c;
         end
         if (baud_valid && baud_err) both++;
         if (busy) busy_cnt++;
         meas_valid = (c == inj_a) || (c == inj_b);
         reset_n    = (c != rst_at);
         @(negedge clk);
      end
      meas_valid = 1'b0;
      reset_n    = 1'b1;
   endtask

   task automatic test_reset();
      reset_n     = 1'b0;
      meas_valid  = 1'b0;
      meas_cycles = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, baud_valid, baud_err} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 000", {busy, baud_valid, baud_err});
      end
      checks++;
      if (bit_div !== 20'd0 || os_div !== 20'd0) begin
         errors++;
         $display("FAIL reset_divs: got %0d/%0d expected 0/0", bit_div, os_div);
      end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_115200();
      int fv, lv, fe, nv, ne, bc, bo;
      run_meas(20'd3472, -1, -1, -1, 55, fv, lv, fe, nv, ne, bc, bo);
      checks++;
      if (fv !== 47 || nv !== 1 || ne !== 0) begin
         errors++;
         $display("FAIL b115200_timing: got cycle %0d valids %0d errs %0d expected 47/1/0", fv, nv, ne);
      end
      checks++;
      if (bc !== 47) begin
         errors++;
         $display("FAIL b115200_busy: got %0d busy cycles expected 47", bc);
      end
      checks++;
      if (bit_div !== 20'd434 || os_div !== 20'd27) begin
         errors++;
         $display("FAIL b115200_divs: got %0d/%0d expected 434/27", bit_div, os_div);
      end
   endtask

   task automatic test_errors();
      int fv, lv, fe, nv, ne, bc, bo;
      run_meas(20'd40, -1, -1, -1, 55, fv, lv, fe, nv, ne, bc, bo);
      checks++;
      if (fe !== 47 || ne !== 1 || nv !== 0) begin
         errors++;
         $display("FAIL err40_timing: got cycle %0d errs %0d valids %0d expected 47/1/0", fe, ne, nv);
      end
      checks++;
      if (bit_div !== 20'd434 || os_div !== 20'd27) begin
         errors++;
         $display("FAIL err40_hold: got %0d/%0d expected 434/27", bit_div, os_div);
      end
      run_meas(20'd0, -1, -1, -1, 55, fv, lv, fe, nv, ne, bc, bo);
      checks++;
      if (fe !== 47 || ne !== 1 || nv !== 0 || bit_div !== 20'd434 || os_div !== 20'd27) begin
         errors++;
         $display("FAIL err0: got cycle %0d errs %0d valids %0d divs %0d/%0d expected 47/1/0 434/27",
                  fe, ne, nv, bit_div, os_div);
      end
   endtask

   task automatic test_9600();
      int fv, lv, fe, nv, ne, bc, bo;
      run_meas(20'd41667, -1, -1, -1, 55, fv, lv, fe, nv, ne, bc, bo);
      checks++;
      if (fv !== 47 || bit_div !== 20'd5208 || os_div !== EXP_9600_OS) begin
         errors++;
         $display("FAIL b9600: got cycle %0d divs %0d/%0d expected 47 5208/%0d",
                  fv, bit_div, os_div, EXP_9600_OS);
      end
   endtask

   task automatic test_saturate();
      int fv, lv, fe, nv, ne, bc, bo;
      run_meas(20'hFFFFF, -1, -1, -1, 55, fv, lv, fe, nv, ne, bc, bo);
      checks++;
      if (fv !== 47 || bit_div !== 20'd131071 || os_div !== EXP_SAT_OS) begin
         errors++;
         $display("FAIL saturate: got cycle %0d divs %0d/%0d expected 47 131071/%0d",
                  fv, bit_div, os_div, EXP_SAT_OS);
      end
   endtask

   task automatic test_back_to_back();
      int fv, lv, fe, nv, ne, bc, bo;
      // Pulses while busy and coincident with the result are dropped
      run_meas(20'd3472, 10, 47, -1, 60, fv, lv, fe, nv, ne, bc, bo);
      checks++;
      if (nv !== 1 || fv !== 47 || bc !== 47) begin
         errors++;
         $display("FAIL drop_busy: got valids %0d first %0d busy %0d expected 1/47/47", nv, fv, bc);
      end
      // A pulse in the first idle cycle starts a new measurement
      run_meas(20'd41667, 48, -1, -1, 100, fv, lv, fe, nv, ne, bc, bo);
      checks++;
      if (nv !== 2 || fv !== 47 || lv !== 95) begin
         errors++;
         $display("FAIL accept_48: got valids %0d first %0d last %0d expected 2/47/95", nv, fv, lv);
      end
      checks++;
      if (bo !== 0 || ne !== 0) begin
         errors++;
         $display("FAIL exclusive: got overlap %0d errs %0d expected 0/0", bo, ne);
      end
   endtask

   task automatic test_reset_mid();
      int fv, lv, fe, nv, ne, bc, bo;
      run_meas(20'd3472, -1, -1, 20, 60, fv, lv, fe, nv, ne, bc, bo);
      checks++;
      if (nv !== 0 || ne !== 0 || bc !== 20) begin
         errors++;
         $display("FAIL reset_mid_abort: got valids %0d errs %0d busy %0d expected 0/0/20", nv, ne, bc);
      end
      checks++;
      if (bit_div !== 20'd0 || os_div !== 20'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_outs: got %0d/%0d busy %b expected 0/0/0", bit_div, os_div, busy);
      end
      run_meas(20'd3472, -1, -1, -1, 55, fv, lv, fe, nv, ne, bc, bo);
      checks++;
      if (fv !== 47 || nv !== 1 || bit_div !== 20'd434 || os_div !== 20'd27) begin
         errors++;
         $display("FAIL after_reset: got cycle %0d valids %0d divs %0d/%0d expected 47/1 434/27",
                  fv, nv, bit_div, os_div);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_115200();
      test_errors();
      test_9600();
      test_saturate();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/autobaud_div_seq.md
# autobaud_div_seq

Sequencer between the autobaud edge-measurement logic and the shared radix-2 serial divider `div`. It converts one measured sync-character span (clock cycles across `BITS` bit times) into a bit-period divisor and an oversample-tick divisor by issuing two back-to-back divisions on a single `div` instance. The result is then handed to the baud-tick generator with a one-cycle valid pulse.

## Interface
- `W`, 20: datapath width of measurement, divisors and the internal `div` instance.
- `N`, 6: `div` counter width; must satisfy `N >= clog2(W)+1`.
- `BITS`, 8: bit times covered by one measurement; must be ≥ 1.
- `OVS`, 16: receiver oversample factor; must be ≥ 1.
- `MIN_BIT_DIV`, 8: smallest accepted bit divisor.
- `clk`  in  1: clock; single domain.
- `reset_n`  in  1: reset, synchronous, active-low (already decided).
- `meas_valid`  in  1: one-cycle pulse; `meas_cycles` is valid.
- `meas_cycles`  in  W: measured span in clock cycles.
- `busy`  out  1: high from acceptance until the result/error pulse cycle, inclusive.
- `baud_valid`  out  1: one-cycle pulse; new `bit_div`/`os_div` are valid.
- `baud_err`  out  1: one-cycle pulse; measurement rejected.
- `bit_div`  out  W: cycles per bit; holds the last good value.
- `os_div`  out  W: cycles per oversample tick; holds the last good value.

## Operation
- States: IDLE, DIV1, WAIT1, DIV2, WAIT2, CHECK.
- IDLE: on `meas_valid`, latch `meas_cycles` and go to DIV1. `meas_valid` in any other state is dropped, with no queuing and no error.
- DIV1: drive `div.start=1` for exactly one cycle, with dividend = `meas_cycles` (+`BITS/2` if rounding) and divisor = `BITS`. Go to WAIT1.
- WAIT1: on `div.done_tick`, latch `quotient` as q1 and go to DIV2.
- DIV2: drive `start` for one cycle, with dividend = q1 (+`OVS/2` if rounding) and divisor = `OVS`. Go to WAIT2.
- WAIT2: on `done_tick`, latch q2 and go to CHECK.
- CHECK: if `q1 < MIN_BIT_DIV` or `q2 == 0`, pulse `baud_err` and leave outputs unchanged. Otherwise load `bit_div=q1`, `os_div=q2` and pulse `baud_valid`. Return to IDLE.
- Arithmetic: a rounding-offset addition is W+1 bits wide and saturates to `2^W-1` on carry-out. Remainders are ignored.
- `div.start` is asserted only while `div.ready=1`. If `ready=0` in DIV1/DIV2, hold the state until it is 1.
- Reset: all outputs are 0 (`busy`, `baud_valid`, `baud_err`, `bit_div`, `os_div`) and the state is IDLE. `reset_n` also drives the `div` instance's reset. Reset mid-division aborts with no pulse.

## Timing
- Let cycle 0 be the edge that samples `meas_valid` in IDLE.
- `div.start` is high in cycle 1 and cycle W+4.
- `div` done_tick arrives at cycles W+3 and 2W+6.
- `baud_valid`/`baud_err` is high in cycle 2W+7, registered. `busy` is high in cycles 1..2W+7.
- Total latency with default W=20 is 47 cycles.
- `meas_valid` is accepted again from cycle 2W+8. A pulse coincident with the result pulse is dropped.
- `baud_valid` and `baud_err` are never high together.

## Configuration
- `AUTOBAUD_ROUND_EN` defined: both dividends get half-divisor offsets (`BITS/2`, `OVS/2`, integer), giving round-to-nearest results.
- `AUTOBAUD_ROUND_EN` undefined: no offsets, truncating division. Port list and latency are identical.

## Structure
- Package `autobaud_pkg` holds:
  - state encoding localparams;
  - default `W`, `BITS`, `OVS`, `MIN_BIT_DIV`;
  - the saturating-add width rule.
- One sub-module: a single `div` instance (`#(W,N)`), owned exclusively by this block. All other logic is a flat FSM.

## Test plan
All cases use defaults W=20, BITS=8, OVS=16.
- Rounding on, `meas_cycles`=3472 (115200 baud @50 MHz) -> `baud_valid` in cycle 47, `bit_div`=434, `os_div`=27.
- Rounding on, 41667 (9600 baud) -> 5208 / 326. Rounding off, same input -> 5208 / 325.
- `meas_cycles`=40 -> `baud_err` at cycle 47, outputs keep prior 434/27. `meas_cycles`=0 -> `baud_err`.
- `meas_cycles`=0xFFFFF with rounding -> offset saturates, `bit_div`=131071, `os_div`=8192, no wrap.
- Second `meas_valid` at cycle 10 and at cycle 47 -> both dropped, exactly one `baud_valid`. A pulse at cycle 48 -> accepted.
- `reset_n`=0 at cycle 20 for 1 cycle -> no pulse, all outputs 0. The next measurement completes in 47 cycles.
